// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a core's data-memory port and
//   mem_responder.
//
//   Handshake: the requester holds Req high with WE/Addr/WriteData/Size
//   stable; the responder captures them on the first rising edge where it is
//   idle and Req = 1. After that edge the requester may change or drop every
//   request signal. Exactly one Ready pulse, lasting one cycle, answers each
//   captured request, and ReadData/Err are meaningful only while Ready = 1.
//   Busy is high from the cycle after capture through the Ready cycle.
//
//   Signals:
//     Req        request valid
//     WE         1 = store, 0 = load
//     Addr       byte address
//     WriteData  store data, right-aligned
//     Size       RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//     Ready      one-cycle response strobe
//     ReadData   load result
//     Err        request faulted
//     Busy       responder not idle
interface mem_responder_if;
  logic        Req;
  logic        WE;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  Size;
  logic        Ready;
  logic [31:0] ReadData;
  logic        Err;
  logic        Busy;

  modport master (
    output Req, WE, Addr, WriteData, Size,
    input  Ready, ReadData, Err, Busy
  );

  modport slave (
    input  Req, WE, Addr, WriteData, Size,
    output Ready, ReadData, Err, Busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Word-organised data RAM behind a Req/Ready handshake. One load or store
//   is accepted at a time; WAIT wait states are inserted before the access,
//   which performs RV32I byte/halfword/word lane steering and load sign/zero
//   extension. Every output is registered.
//
//   Parameters:
//     DEPTH  RAM size in 32-bit words (power of two, >= 4)
//     WAIT   wait-state cycles before the access completes (0..15)
//
//   Ports:
//     clk        clock, rising edge
//     reset      synchronous, active-high
//     bus        mem_responder_if.slave (request in, response out)
//     dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic [1:0]      dbg_state
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  // Only the bits that select a word and a lane are kept; higher address
  // bits alias by design.
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      size_q, size_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic            fault;
  logic [3:0]      be;
  logic [31:0]     st_data;
  logic [31:0]     ld_val;
  logic            access;
  logic            mem_we;

  assign idx  = addr_q[AW+1:2];
  assign word = mem[idx];

  // Access decode from the captured request.
  always_comb begin
    fault     = 1'b0;
    be        = 4'b0000;
    st_data   = 32'h0;
    ld_val    = 32'h0;
    byte_lane = 8'h0;

    case (addr_q[1:0])
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr_q[1] ? word[31:16] : word[15:0];

    case (size_q)
      3'b000, 3'b100: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
        ld_val  = size_q[2] ? {24'h0, byte_lane}
                            : {{24{byte_lane[7]}}, byte_lane};
      end
      3'b001, 3'b101: begin
        if (addr_q[0]) begin
          fault = 1'b1;
        end else begin
          be      = addr_q[1] ? 4'b1100 : 4'b0011;
          st_data = {2{wdata_q[15:0]}};
          ld_val  = size_q[2] ? {16'h0, half_lane}
                              : {{16{half_lane[15]}}, half_lane};
        end
      end
      3'b010: begin
        if (addr_q[1:0] != 2'b00) begin
          fault = 1'b1;
        end else begin
          be      = 4'b1111;
          st_data = wdata_q;
          ld_val  = word;
        end
      end
      default: fault = 1'b1;
    endcase
  end

  // The access happens on the edge that leaves WAIT with the counter at 0.
  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // reset is folded in because the RAM itself is never reset: a reset edge
  // that lands on the access edge must abort the store.
  assign mem_we = access && we_q && !fault && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Req) begin
          we_d    = bus.WE;
          addr_d  = bus.Addr[AW+1:0];
          wdata_d = bus.WriteData;
          size_d  = bus.Size;
          cnt_d   = WAIT_CNT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = fault;
          rdata_d = (fault || we_q) ? 32'h0 : ld_val;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 3'b000;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM: per-lane writes, contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.ReadData = rdata_q;
  assign bus.Err      = err_q;
  assign bus.Busy     = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder (DEPTH = 64, WAIT = 2). Each request
//   pushes its expected ReadData/Err and capture cycle into queues; a
//   negedge monitor pops and compares on every Ready pulse, including the
//   capture-to-Ready latency.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAIT  = 2;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int   cyc;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (bus.Ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got Ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        logic [31:0] e_rd;
        logic        e_err;
        int          e_cyc;
        e_rd  = exp_q.pop_front();
        e_err = exp_err_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        check("rdata", bus.ReadData, e_rd);
        check("err", {31'h0, bus.Err}, {31'h0, e_err});
        // Ready appears WAIT+1 edges after the capture edge.
        check("latency", 32'(cyc - e_cyc), 32'(WAIT + 1));
      end
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.Busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.Busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got Busy=%b expected 0", bus.Busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_err_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] sz);
    bus.Req       = 1'b1;
    bus.WE        = we;
    bus.Addr      = addr;
    bus.WriteData = wd;
    bus.Size      = sz;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] sz, input logic [31:0] exp_rd, input logic exp_err);
    wait_idle();
    drive(we, addr, wd, sz);
    @(posedge clk);
    #1;
    exp_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    exp_cyc_q.push_back(cyc);
    bus.Req       = 1'b0;
    bus.Addr      = 32'hFFFF_FFFF;
    bus.WriteData = 32'hA5A5_A5A5;
    wait_drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, {31'h0, bus.Ready}, 32'h0);
    check({tag, "_rdata"}, bus.ReadData, 32'h0);
    check({tag, "_err"},   {31'h0, bus.Err}, 32'h0);
    check({tag, "_busy"},  {31'h0, bus.Busy}, 32'h0);
  endtask

  // Stimulus
  initial begin
    int c0;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.Req = 1'b0;
    bus.WE = 1'b0;
    bus.Addr = 32'h0;
    bus.WriteData = 32'h0;
    bus.Size = 3'b010;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    check("reset_state", {30'h0, dbg_state}, 32'h0);

    // Word store / load
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0);

    // Byte store, byte loads
    issue(1'b1, 32'h11, 32'h0000_005A, 3'b000, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_5AEF, 1'b0);
    issue(1'b0, 32'h13, 32'h0,         3'b000, 32'hFFFF_FFDE, 1'b0);
    issue(1'b0, 32'h13, 32'h0,         3'b100, 32'h0000_00DE, 1'b0);

    // Halfword store into the upper lane, lower half stays
    issue(1'b1, 32'h20, 32'h1234_5678, 3'b010, 32'h0, 1'b0);
    issue(1'b1, 32'h22, 32'hFFFF_8001, 3'b001, 32'h0, 1'b0);
    issue(1'b0, 32'h22, 32'h0,         3'b001, 32'hFFFF_8001, 1'b0);
    issue(1'b0, 32'h22, 32'h0,         3'b101, 32'h0000_8001, 1'b0);
    issue(1'b0, 32'h20, 32'h0,         3'b010, 32'h8001_5678, 1'b0);
    issue(1'b0, 32'h21, 32'h0,         3'b000, 32'h0000_0056, 1'b0);

    // Faults: no write, ReadData 0
    issue(1'b0, 32'h12, 32'h0,         3'b010, 32'h0, 1'b1);
    issue(1'b1, 32'h13, 32'h0000_1111, 3'b001, 32'h0, 1'b1);
    issue(1'b1, 32'h10, 32'h2222_2222, 3'b011, 32'h0, 1'b1);
    issue(1'b1, 32'h10, 32'h3333_3333, 3'b110, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_5AEF, 1'b0);

    // Aliasing modulo 4*DEPTH bytes
    issue(1'b1, 32'h104, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0);
    issue(1'b0, 32'h004, 32'h0,         3'b010, 32'hCAFE_F00D, 1'b0);

    // Req held high: one acceptance every WAIT+3 cycles
    wait_idle();
    drive(1'b0, 32'h10, 32'h0, 3'b010);
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'hDEAD_5AEF);
      exp_err_q.push_back(1'b0);
      exp_cyc_q.push_back(c0 + k * (WAIT + 3));
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("held_busy", {31'h0, bus.Busy}, ((k % (WAIT + 3)) == (WAIT + 2)) ? 32'h0 : 32'h1);
      if (k == 14) bus.Req = 1'b0;
    end
    wait_drain();

    // Reset during WAIT aborts the store
    wait_idle();
    drive(1'b1, 32'h10, 32'h1111_1111, 3'b010);
    @(posedge clk);
    #1;
    bus.Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("abort");
    repeat (4) @(negedge clk);
    check("abort_no_ready_busy", {31'h0, bus.Busy}, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_5AEF, 1'b0);

    // Reset and Req together: nothing captured
    wait_idle();
    drive(1'b1, 32'h10, 32'h4444_4444, 3'b010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.Req = 1'b0;
    check_outputs_zero("rst_req");
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_5AEF, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
